// File: rtl/tpu_acc_pkg.sv
// rtl/tpu_acc_pkg.sv - shared types and sizes for the TPU accumulator bank
package tpu_acc_pkg;

    localparam int ACC_DW    = 32;
    localparam int ACC_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } acc_state_t;

endpackage

// File: rtl/acc_bank.sv
// rtl/acc_bank.sv - DEPTH x DW accumulator storage, one write and one async read port
module acc_bank #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/acc_bank_ctrl.sv
// rtl/acc_bank_ctrl.sv - FILL/DRAIN sequencer for the accumulator bank
// Optional ACC_BANK_CTRL_SUM_EN adds acc_clear and read-modify-write accumulation.
module acc_bank_ctrl
    import tpu_acc_pkg::*;
#(
    parameter int DW    = ACC_DW,
    parameter int DEPTH = ACC_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW:0]   num_rows,
`ifdef ACC_BANK_CTRL_SUM_EN
    input  logic          acc_clear,
`endif
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    acc_state_t    state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   rows;
    logic [AW:0]   rows_clamped;
    logic          beat;
    logic          xfer;
    logic          last_beat;
    logic          last_xfer;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] wr_data;

    assign beat         = in_valid && in_ready;
    assign xfer         = out_valid && out_ready;
    assign last_beat    = ({1'b0, wr_ptr} + (AW+1)'(1)) == rows;
    assign last_xfer    = ({1'b0, rd_ptr} + (AW+1)'(1)) == rows;
    assign rows_clamped = (num_rows > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_rows;
    // FILL reads the entry being written; DRAIN prefetches the entry after the one on out_data.
    assign rd_addr      = (state == DRAIN) ? rd_ptr + AW'(1) : wr_ptr;

`ifdef ACC_BANK_CTRL_SUM_EN
    logic clear_q;
    assign wr_data = clear_q ? in_data : rd_data + in_data;
`else
    assign wr_data = in_data;
`endif

    acc_bank #(.DW(DW), .DEPTH(DEPTH)) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (beat),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rows      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef ACC_BANK_CTRL_SUM_EN
            clear_q   <= 1'b1;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rows <= rows_clamped;
`ifdef ACC_BANK_CTRL_SUM_EN
                        clear_q <= acc_clear;
`endif
                        if (num_rows == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= FILL;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (beat) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        // Entry 0 is captured on the way in so DRAIN can present it on entry.
                        if (wr_ptr == '0) out_data <= wr_data;
                        if (last_beat) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            wr_ptr    <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        if (last_xfer) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            rd_ptr    <= '0;
                        end else begin
                            rd_ptr   <= rd_ptr + AW'(1);
                            out_data <= rd_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_bank_ctrl.sv
// tb/tb_acc_bank_ctrl.sv - randomized self-checking bench for acc_bank_ctrl with a row-level model
module tb_acc_bank_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  num_rows = 3'd0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
`ifdef ACC_BANK_CTRL_SUM_EN
    logic        acc_clear = 1'b1;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mbank [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] dir_data [$];
    logic        rdy_pat [$];

    always #5 clk = ~clk;

    acc_bank_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .num_rows  (num_rows),
`ifdef ACC_BANK_CTRL_SUM_EN
        .acc_clear (acc_clear),
`endif
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) mbank[i] = 32'd0;
    endtask

    // One tile: the model expects the first min(n, DEPTH) accepted values back in order.
    task automatic tile(input int n, input int vprob, input int rprob);
        int          r;
        int          acc;
        int          idx;
        int          cyc;
        logic [31:0] d;
        r = (n > DEPTH) ? DEPTH : n;
        start    = 1'b1;
        num_rows = n[2:0];
        step();
        start = 1'b0;
        if (r == 0) begin
            chk1("zero_done", done, 1'b1);
            chk1("zero_busy", busy, 1'b0);
            chk1("zero_in_ready", in_ready, 1'b0);
            step();
            chk1("zero_done_pulse", done, 1'b0);
            chk1("zero_busy_after", busy, 1'b0);
            return;
        end
        chk1("fill_busy", busy, 1'b1);
        acc = 0;
        cyc = 0;
        while (acc < r && cyc < 200) begin
            chk1("fill_in_ready", in_ready, 1'b1);
            chk1("fill_out_valid", out_valid, 1'b0);
            in_valid = ($urandom_range(99) < vprob);
            d = $urandom;
            if (in_valid && dir_data.size() > 0) d = dir_data.pop_front();
            in_data  = d;
            start    = ($urandom_range(1) == 1);
            num_rows = 3'($urandom);
            step();
            cyc++;
            if (in_valid) begin
`ifdef ACC_BANK_CTRL_SUM_EN
                mbank[acc] = acc_clear ? d : mbank[acc] + d;
`else
                mbank[acc] = d;
`endif
                exp_q.push_back(mbank[acc]);
                acc++;
            end
        end
        if (acc < r) chk("fill_timeout_beats", acc, r);
        idx = 0;
        cyc = 0;
        while (idx < r && cyc < 200) begin
            chk1("drain_in_ready", in_ready, 1'b0);
            chk1("drain_out_valid", out_valid, 1'b1);
            chk("drain_data", out_data, exp_q[idx]);
            in_valid  = ($urandom_range(1) == 1);
            in_data   = $urandom;
            start     = ($urandom_range(1) == 1);
            num_rows  = 3'($urandom);
            out_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : ($urandom_range(99) < rprob);
            step();
            cyc++;
            if (out_ready) idx++;
        end
        if (idx < r) chk("drain_timeout_xfers", idx, r);
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk1("end_done", done, 1'b1);
        chk1("end_busy", busy, 1'b0);
        chk1("end_out_valid", out_valid, 1'b0);
        step();
        chk1("end_done_pulse", done, 1'b0);
        chk1("end_in_ready", in_ready, 1'b0);
        exp_q.delete();
    endtask

    initial begin
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk("rst_out_data", out_data, 32'd0);
        reset_n = 1'b1;
        step();

        dir_data = '{32'd10, 32'd20, 32'd30, 32'd40};
        tile(4, 100, 100);

        dir_data = '{32'd10, 32'd20, 32'd30, 32'd40};
        rdy_pat  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tile(4, 100, 100);

        tile(0, 100, 100);
        tile(7, 100, 100);

        start    = 1'b1;
        num_rows = 3'd4;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'd1;
        step();
        in_data  = 32'd2;
        step();
        in_data  = 32'd3;
        #2;
        reset_n  = 1'b0;
        #1;
        chk1("abort_in_ready", in_ready, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_out_valid", out_valid, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk("abort_out_data", out_data, 32'd0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        clear_model();
        step();
        dir_data = '{32'd5, 32'd6};
        tile(2, 100, 100);

`ifdef ACC_BANK_CTRL_SUM_EN
        acc_clear = 1'b1;
        dir_data  = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFF};
        tile(4, 100, 100);
        acc_clear = 1'b0;
        dir_data  = '{32'd1, 32'd1, 32'd1, 32'd1};
        tile(4, 100, 100);
`endif

        for (int t = 0; t < 25; t++) begin
`ifdef ACC_BANK_CTRL_SUM_EN
            acc_clear = ($urandom_range(1) == 1);
`endif
            tile($urandom_range(7), 60, 60);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
